rope_seq: RTL and testbench
===========================

# rope_seq

Job sequencer that drives the two-phase RoPE engine from the initiator side. It accepts one rotary-embedding job (two phases of Q/K projection, cos and sin operands) on a valid/ready port, holds each phase's operands stable, and pulses start1 and then start2. It tracks the engine's busy_RoPE handshake and captures the rotated result. It returns the result on a valid/ready port and sits between the attention datapath's operand staging and the RoPE engine.

## Interface
- BW_FP, 17: floating-point word width.
- VALUE_MN, 64: elements per phase operand.
- TIMEOUT, 15: maximum cycles in a wait state before abort (4-bit counter, must be ≥8).
- clk  in  1  clock.
- rst_n  in  1  reset; **asynchronous, active-low**.
- job_valid  in  1  job offered.
- job_ready  out  1  job accepted when job_valid&&job_ready at a rising edge.
- job_qk1/job_cos1/job_sin1  in  VALUE_MN*BW_FP each  phase-1 operands.
- job_qk2/job_cos2/job_sin2  in  VALUE_MN*BW_FP each  phase-2 operands.
- start1, start2  out  1  one-cycle start pulses to the engine.
- QK_proj, W_cos, W_sin  out  VALUE_MN*BW_FP each  operands to the engine.
- busy_RoPE  in  1  engine busy.
- buffer_RoPE  in  VALUE_MN*2*BW_FP  engine result.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed on res_valid&&res_ready.
- res_data  out  VALUE_MN*2*BW_FP  captured result.
- err_timeout  out  1  sticky abort flag.
- err_clr  in  1  clears err_timeout.

## Operation
- States: IDLE, S1_GO, S1_WAIT, S2_GO, S2_WAIT, OUT.
- IDLE:
  - job_ready = !busy_RoPE; it is low in every other state.
  - On accept, latch all six operand buses and go to S1_GO.
- S1_GO:
  - start1=1 for this single cycle.
  - Clear seen_busy and the watchdog counter, then go to S1_WAIT.
- S1_WAIT:
  - busy_RoPE=1 sets seen_busy.
  - When seen_busy is set (registered) and busy_RoPE=0, go to S2_GO.
- S2_GO / S2_WAIT: identical to S1_GO / S1_WAIT, using start2.
- Leaving S2_WAIT: load res_data ← buffer_RoPE on the same edge and go to OUT.
- OUT:
  - res_valid=1 while in OUT; res_data holds stable.
  - On res_ready go to IDLE.
- Operand outputs are combinational from the state:
  - S1_GO/S1_WAIT drive the phase-1 latched set.
  - S2_GO/S2_WAIT drive the phase-2 set.
  - All other states drive zero.
  - Operands are stable from the GO cycle until the WAIT state is left.
- Watchdog:
  - The counter increments each cycle in S1_WAIT/S2_WAIT.
  - On reaching TIMEOUT: set err_timeout, go to IDLE, discard the job and do not assert res_valid.
  - This covers both busy never rising and busy stuck high.
- err_timeout stays set until err_clr. If err_clr and a new timeout occur in the same cycle, the flag stays set.
- start1 and start2 are never high in the same cycle, and never high outside the GO states.
- There is no arithmetic on data; widths pass through unchanged.

## Timing
- Reset values: state IDLE; start1, start2, res_valid and err_timeout 0; res_data 0; operand outputs 0; job_ready = !busy_RoPE.
- Reset mid-operation: immediate return to IDLE, latched operands and res_data cleared, no further starts.
- Nominal engine timing: busy high for 3 cycles after start1, 7 cycles after start2. With an accept at edge 0:
  - start1 high in cycle 1; busy in cycles 2–4; low observed in cycle 5.
  - start2 high in cycle 6; busy in cycles 7–13; low observed in cycle 14.
  - res_data captured at edge 14; res_valid high from cycle 15.
- res_valid deasserts the cycle after the handshake edge. The next job can be accepted at the first IDLE cycle, giving a throughput of one job per 16 cycles with res_ready=1.

## Test plan
- Nominal job:
  - Stimulus: job_qk1 all 17'h0A000, engine model with 3/7-cycle busy, buffer_RoPE = 0x1234-pattern, res_ready=1.
  - Required: start1 in cycle 1 and start2 in cycle 6 after accept; res_valid in cycle 15 with res_data = pattern; QK_proj = job_qk1 during cycles 1–5 and job_qk2 during cycles 6–14.
- Backpressure:
  - Stimulus: res_ready=0 for 5 cycles after res_valid.
  - Required: res_valid and res_data hold; job_ready stays 0; IDLE follows the handshake.
- Busy never rises:
  - Stimulus: engine ignores start1.
  - Required: err_timeout=1 after TIMEOUT (15) cycles in S1_WAIT; no start2; no res_valid.
  - Then err_clr=1 for 1 cycle → err_timeout=0.
- Engine occupied:
  - Stimulus: busy_RoPE=1 in IDLE with job_valid=1.
  - Required: job_ready=0 and no accept until busy_RoPE drops.
- Reset mid-job:
  - Stimulus: rst_n low in S2_WAIT.
  - Required: all outputs at reset values; no res_valid; next job runs nominally.
- Back-to-back:
  - Stimulus: two jobs with job_valid held, res_ready=1.
  - Required: second start1 exactly 16 cycles after the first; results delivered in order.

Source files
------------

// File: rtl/rope_seq.sv
// rope_seq: initiator-side job sequencer for the two-phase RoPE engine.
//
// Accepts one rotary-embedding job (phase-1 and phase-2 Q/K, cos and sin
// operands), latches it, then walks the engine through both phases. Each
// phase raises a one-cycle start pulse and holds that phase's operands on
// QK_proj/W_cos/W_sin. The phase ends when busy_RoPE has been seen high and
// then falls. After phase 2 the engine result is captured and offered on a
// valid/ready port. A per-phase watchdog aborts a job whose engine never
// raises busy, or never drops it. An abort sets a sticky error flag.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   job_valid/job_ready   job handshake (ready only when idle and engine free)
//   job_qk1/cos1/sin1     phase-1 operands
//   job_qk2/cos2/sin2     phase-2 operands
//   start1, start2        one-cycle start pulses to the engine
//   QK_proj, W_cos, W_sin operands to the engine (zero outside a phase)
//   busy_RoPE             engine busy
//   buffer_RoPE           engine result
//   res_valid/res_ready   result handshake
//   res_data              captured result, stable while res_valid
//   err_timeout           sticky watchdog abort flag
//   err_clr               clears err_timeout (a same-cycle abort wins)
module rope_seq #(
    parameter int unsigned BW_FP    = 17,
    parameter int unsigned VALUE_MN = 64,
    // Watchdog limit in wait-state cycles; must fit the 4-bit counter (8..15)
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic [VALUE_MN*BW_FP-1:0]    job_qk1,
    input  logic [VALUE_MN*BW_FP-1:0]    job_cos1,
    input  logic [VALUE_MN*BW_FP-1:0]    job_sin1,
    input  logic [VALUE_MN*BW_FP-1:0]    job_qk2,
    input  logic [VALUE_MN*BW_FP-1:0]    job_cos2,
    input  logic [VALUE_MN*BW_FP-1:0]    job_sin2,

    output logic                         start1,
    output logic                         start2,
    output logic [VALUE_MN*BW_FP-1:0]    QK_proj,
    output logic [VALUE_MN*BW_FP-1:0]    W_cos,
    output logic [VALUE_MN*BW_FP-1:0]    W_sin,
    input  logic                         busy_RoPE,
    input  logic [VALUE_MN*2*BW_FP-1:0]  buffer_RoPE,

    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [VALUE_MN*2*BW_FP-1:0]  res_data,

    output logic                         err_timeout,
    input  logic                         err_clr
);

    localparam int unsigned OpW = VALUE_MN * BW_FP;
    localparam int unsigned ResW = 2 * OpW;
    // Abort fires in the wait cycle where the counter already holds TIMEOUT-1,
    // i.e. after TIMEOUT full cycles in the wait state.
    localparam logic [3:0] WdLast = 4'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StS1Go,
        StS1Wait,
        StS2Go,
        StS2Wait,
        StOut
    } state_e;

    state_e state_q, state_d;

    logic           seen_busy_q, seen_busy_d;
    logic [3:0]     wd_cnt_q, wd_cnt_d;
    logic           err_q, err_d;
    logic           accept;
    logic           capture;
    logic           timeout;

    logic [OpW-1:0] qk1_q, cos1_q, sin1_q;
    logic [OpW-1:0] qk2_q, cos2_q, sin2_q;
    logic [ResW-1:0] res_data_q;

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        seen_busy_d = seen_busy_q;
        wd_cnt_d    = wd_cnt_q;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (job_valid && !busy_RoPE) begin
                    accept  = 1'b1;
                    state_d = StS1Go;
                end
            end
            StS1Go, StS2Go: begin
                seen_busy_d = 1'b0;
                wd_cnt_d    = 4'd0;
                state_d     = (state_q == StS1Go) ? StS1Wait : StS2Wait;
            end
            StS1Wait, StS2Wait: begin
                if (busy_RoPE) begin
                    seen_busy_d = 1'b1;
                end
                // Completion uses the registered flag so a busy pulse must be
                // observed in an earlier cycle than the falling edge.
                if (seen_busy_q && !busy_RoPE) begin
                    if (state_q == StS1Wait) begin
                        state_d = StS2Go;
                    end else begin
                        capture = 1'b1;
                        state_d = StOut;
                    end
                end else if (wd_cnt_q == WdLast) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end else begin
                    wd_cnt_d = wd_cnt_q + 4'd1;
                end
            end
            StOut: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sticky error: a new abort takes priority over a clear in the same cycle
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            seen_busy_q <= 1'b0;
            wd_cnt_q    <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            seen_busy_q <= seen_busy_d;
            wd_cnt_q    <= wd_cnt_d;
            err_q       <= err_d;
        end
    end

    // Job operand latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qk1_q  <= '0;
            cos1_q <= '0;
            sin1_q <= '0;
            qk2_q  <= '0;
            cos2_q <= '0;
            sin2_q <= '0;
        end else if (accept) begin
            qk1_q  <= job_qk1;
            cos1_q <= job_cos1;
            sin1_q <= job_sin1;
            qk2_q  <= job_qk2;
            cos2_q <= job_cos2;
            sin2_q <= job_sin2;
        end
    end

    // Result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_q <= '0;
        end else if (capture) begin
            res_data_q <= buffer_RoPE;
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        QK_proj = '0;
        W_cos   = '0;
        W_sin   = '0;
        unique case (state_q)
            StS1Go, StS1Wait: begin
                QK_proj = qk1_q;
                W_cos   = cos1_q;
                W_sin   = sin1_q;
            end
            StS2Go, StS2Wait: begin
                QK_proj = qk2_q;
                W_cos   = cos2_q;
                W_sin   = sin2_q;
            end
            default: begin
            end
        endcase
    end

    assign start1      = (state_q == StS1Go);
    assign start2      = (state_q == StS2Go);
    assign job_ready   = (state_q == StIdle) && !busy_RoPE;
    assign res_valid   = (state_q == StOut);
    assign res_data    = res_data_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_rope_seq.sv
// Directed self-checking bench for rope_seq with a small engine model that
// holds busy for 3 cycles after start1 and 7 cycles after start2.
module tb_rope_seq;

    localparam int unsigned BW_FP    = 17;
    localparam int unsigned VALUE_MN = 64;
    localparam int unsigned TIMEOUT  = 15;
    localparam int unsigned OW       = VALUE_MN * BW_FP;
    localparam int unsigned RW       = 2 * OW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          job_valid;
    logic          job_ready;
    logic [OW-1:0] job_qk1, job_cos1, job_sin1, job_qk2, job_cos2, job_sin2;
    logic          start1, start2;
    logic [OW-1:0] QK_proj, W_cos, W_sin;
    logic          busy_RoPE;
    logic [RW-1:0] buffer_RoPE;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_data;
    logic          err_timeout;
    logic          err_clr;

    // Engine model controls
    logic          eng_ignore = 1'b0;
    logic          eng_echo   = 1'b0;
    logic          busy_force = 1'b0;
    logic [3:0]    busy_cnt   = 4'd0;
    logic [RW-1:0] buf_fixed  = '0;
    logic [RW-1:0] buf_echo   = '0;

    int checks = 0;
    int errors = 0;

    logic [OW-1:0] exp_qk, exp_cos, exp_sin;
    logic [RW-1:0] pat, pat2;
    logic [RW-1:0] exp_res [2];
    int cyc, n_acc, n_res, s1a, s1b;
    logic acc;

    rope_seq #(
        .BW_FP    (BW_FP),
        .VALUE_MN (VALUE_MN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_qk1     (job_qk1),
        .job_cos1    (job_cos1),
        .job_sin1    (job_sin1),
        .job_qk2     (job_qk2),
        .job_cos2    (job_cos2),
        .job_sin2    (job_sin2),
        .start1      (start1),
        .start2      (start2),
        .QK_proj     (QK_proj),
        .W_cos       (W_cos),
        .W_sin       (W_sin),
        .busy_RoPE   (busy_RoPE),
        .buffer_RoPE (buffer_RoPE),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    // Engine model; in echo mode the result is {phase-2 QK, phase-2 sin}
    always @(posedge clk) begin
        if (!rst_n) begin
            busy_cnt <= 4'd0;
        end else if (start1 && !eng_ignore) begin
            busy_cnt <= 4'd3;
        end else if (start2 && !eng_ignore) begin
            busy_cnt <= 4'd7;
        end else if (busy_cnt != 4'd0) begin
            busy_cnt <= busy_cnt - 4'd1;
        end
        if (start2) begin
            buf_echo <= {QK_proj, W_sin};
        end
    end

    assign busy_RoPE   = busy_force || (busy_cnt != 4'd0);
    assign buffer_RoPE = eng_echo ? buf_echo : buf_fixed;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [RW-1:0] got,
                          input logic [RW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got[63:0]=%h exp[63:0]=%h", tag, got[63:0], exp[63:0]);
        end
    endtask

    task automatic checki(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_ops(input logic [16:0] b);
        logic [16:0] v1, v2, v3, v4, v5;
        v1 = b + 17'd1;
        v2 = b + 17'd2;
        v3 = b + 17'd3;
        v4 = b + 17'd4;
        v5 = b + 17'd5;
        job_qk1  = {VALUE_MN{b}};
        job_qk2  = {VALUE_MN{v1}};
        job_cos1 = {VALUE_MN{v2}};
        job_sin1 = {VALUE_MN{v3}};
        job_cos2 = {VALUE_MN{v4}};
        job_sin2 = {VALUE_MN{v5}};
    endtask

    // Offer a job for one edge; returns in cycle 1 after the accept edge
    task automatic accept_job();
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
    endtask

    // Bounded wait for res_valid; n = ticks taken
    task automatic wait_res(input int limit, output int n);
        n = 0;
        while (!res_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1);
    end

    initial begin
        pat  = {2 * VALUE_MN{17'h01234}};
        pat2 = {2 * VALUE_MN{17'h0ABCD}};
        rst_n     = 1'b0;
        job_valid = 1'b0;
        res_ready = 1'b1;
        err_clr   = 1'b0;
        buf_fixed = pat;
        set_ops(17'h0A000);
        tick();
        tick();

        // Reset state
        check1("rst_start1", start1, 1'b0);
        check1("rst_start2", start2, 1'b0);
        check1("rst_res_valid", res_valid, 1'b0);
        check1("rst_err", err_timeout, 1'b0);
        check1("rst_job_ready", job_ready, 1'b1);
        checkw("rst_res_data", res_data, '0);
        checkw("rst_qk", RW'(QK_proj), '0);
        rst_n = 1'b1;
        tick();

        // Nominal job: cycle-by-cycle against the reference timeline
        accept_job();
        for (int c = 1; c <= 16; c++) begin
            exp_qk  = (c <= 5) ? job_qk1  : (c <= 14) ? job_qk2  : '0;
            exp_cos = (c <= 5) ? job_cos1 : (c <= 14) ? job_cos2 : '0;
            exp_sin = (c <= 5) ? job_sin1 : (c <= 14) ? job_sin2 : '0;
            check1($sformatf("nom_start1_c%0d", c), start1, c == 1);
            check1($sformatf("nom_start2_c%0d", c), start2, c == 6);
            check1($sformatf("nom_res_valid_c%0d", c), res_valid, c == 15);
            check1($sformatf("nom_job_ready_c%0d", c), job_ready, c == 16);
            checkw($sformatf("nom_qk_c%0d", c), RW'(QK_proj), RW'(exp_qk));
            checkw($sformatf("nom_cos_c%0d", c), RW'(W_cos), RW'(exp_cos));
            checkw($sformatf("nom_sin_c%0d", c), RW'(W_sin), RW'(exp_sin));
            if (c == 15) begin
                checkw("nom_res_data", res_data, pat);
            end
            tick();
        end

        // Backpressure: result must hold while res_ready is low
        set_ops(17'h01000);
        buf_fixed = pat2;
        res_ready = 1'b0;
        accept_job();
        wait_res(40, cyc);
        checki("bp_latency", cyc, 14);
        buf_fixed = pat;
        for (int i = 0; i < 5; i++) begin
            check1("bp_res_valid_hold", res_valid, 1'b1);
            checkw("bp_res_data_hold", res_data, pat2);
            check1("bp_job_ready_low", job_ready, 1'b0);
            tick();
        end
        res_ready = 1'b1;
        check1("bp_res_valid_at_hs", res_valid, 1'b1);
        tick();
        check1("bp_res_valid_after_hs", res_valid, 1'b0);
        check1("bp_idle_after_hs", job_ready, 1'b1);

        // Busy never rises: watchdog abort after TIMEOUT cycles in S1_WAIT
        eng_ignore = 1'b1;
        accept_job();
        for (int c = 1; c <= 16; c++) begin
            check1("to_no_start2", start2, 1'b0);
            check1("to_no_res_valid", res_valid, 1'b0);
            check1("to_err_not_yet", err_timeout, 1'b0);
            tick();
        end
        check1("to_err_set", err_timeout, 1'b1);
        check1("to_res_valid", res_valid, 1'b0);
        check1("to_back_idle", job_ready, 1'b1);
        checkw("to_qk_zero", RW'(QK_proj), '0);
        tick();
        tick();
        check1("to_err_sticky", err_timeout, 1'b1);

        // Second abort coinciding with err_clr keeps the flag set
        accept_job();
        for (int c = 1; c < 16; c++) begin
            tick();
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check1("to_clr_vs_set", err_timeout, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check1("to_err_cleared", err_timeout, 1'b0);
        eng_ignore = 1'b0;

        // Engine occupied: no accept while busy_RoPE is high
        busy_force = 1'b1;
        job_valid  = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check1("occ_job_ready_low", job_ready, 1'b0);
            check1("occ_no_start1", start1, 1'b0);
            tick();
        end
        busy_force = 1'b0;
        #1;
        check1("occ_job_ready_high", job_ready, 1'b1);
        tick();
        job_valid = 1'b0;
        check1("occ_start1", start1, 1'b1);
        wait_res(40, cyc);
        checki("occ_latency", cyc, 14);
        checkw("occ_res_data", res_data, pat);
        tick();

        // Reset mid-job in S2_WAIT
        buf_fixed = pat2;
        accept_job();
        for (int c = 1; c < 8; c++) begin
            tick();
        end
        check1("rmj_in_phase2", QK_proj === job_qk2, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("rmj_start1", start1, 1'b0);
        check1("rmj_start2", start2, 1'b0);
        check1("rmj_res_valid", res_valid, 1'b0);
        check1("rmj_err", err_timeout, 1'b0);
        checkw("rmj_res_data", res_data, '0);
        checkw("rmj_qk", RW'(QK_proj), '0);
        checkw("rmj_cos", RW'(W_cos), '0);
        checkw("rmj_sin", RW'(W_sin), '0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check1("rmj_quiet_rv", res_valid, 1'b0);
            check1("rmj_quiet_s1", start1, 1'b0);
            tick();
        end
        accept_job();
        check1("rmj_next_start1", start1, 1'b1);
        wait_res(40, cyc);
        checki("rmj_next_latency", cyc, 14);
        checkw("rmj_next_res_data", res_data, pat2);
        tick();

        // Back-to-back with job_valid held; results echo phase-2 operands
        eng_echo = 1'b1;
        set_ops(17'h02000);
        exp_res[0] = {job_qk2, job_sin2};
        job_valid = 1'b1;
        n_acc = 0;
        n_res = 0;
        s1a   = -1;
        s1b   = -1;
        for (int c = 0; c < 60 && n_res < 2; c++) begin
            if (start1) begin
                if (s1a < 0) s1a = c;
                else s1b = c;
            end
            if (res_valid) begin
                checkw($sformatf("b2b_res%0d", n_res), res_data, exp_res[n_res]);
                n_res++;
            end
            acc = job_valid && job_ready;
            tick();
            if (acc) begin
                n_acc++;
                if (n_acc == 1) begin
                    set_ops(17'h03000);
                    exp_res[1] = {job_qk2, job_sin2};
                end else begin
                    job_valid = 1'b0;
                end
            end
        end
        checki("b2b_accepts", n_acc, 2);
        checki("b2b_results", n_res, 2);
        checki("b2b_start_spacing", s1b - s1a, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
